// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM encodings, frame geometry and the
// helper that builds the three upper frame bits for each data/parity mode.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2
  } tx_state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DEFAULT_KW = 19;

  // Upper three frame bits {b10, b9, b8}; parity is XOR of the data bits
  // with OHEL so that ohel=0 yields an even number of ones overall.
  function automatic logic [2:0] frame_tail(input logic [7:0] data,
                                            input logic       eight,
                                            input logic       pen,
                                            input logic       ohel);
    logic p7;
    logic p8;
    p7 = (^data[6:0]) ^ ohel;
    p8 = (^data[7:0]) ^ ohel;
    case ({eight, pen})
      2'b00:   frame_tail = 3'b111;
      2'b01:   frame_tail = {2'b11, p7};
      2'b10:   frame_tail = {2'b11, data[7]};
      default: frame_tail = {1'b1, p8, data[7]};
    endcase
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Baud-rate timer: counts 0..K while run is high and pulses BTU for one
// cycle on the terminal count; held at zero whenever run is low.
module tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned KW = DEFAULT_KW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [KW-1:0] K,
  output logic          BTU
);

  logic [KW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!run || (cnt == K)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign BTU = run && (cnt == K);

endmodule

// File: rtl/tx_engine.sv
// UART transmit engine: accepts a byte in IDLE, frames it with start,
// optional parity and stop bits, and shifts it out LSB first on TX.
module tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned KW = DEFAULT_KW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          LOAD,
  input  logic [7:0]    OUT_PORT,
  input  logic          EIGHT,
  input  logic          PEN,
  input  logic          OHEL,
  input  logic [KW-1:0] K,
  output logic          TX,
  output logic          TXRDY
);

  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  tx_state_e             state;
  tx_state_e             state_n;
  logic [7:0]            data_q;
  logic                  eight_q;
  logic                  pen_q;
  logic                  ohel_q;
  logic [KW-1:0]         k_q;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_n;
  logic [3:0]            bit_cnt;
  logic [3:0]            bit_cnt_n;
  logic                  tx_q;
  logic                  btu;
  logic                  accept;

  assign accept = (state == IDLE) && LOAD;

  tx_bit_timer #(
    .KW(KW)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .run  (state == SHIFT),
    .K    (k_q),
    .BTU  (btu)
  );

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    case (state)
      IDLE: begin
        if (LOAD) state_n = ARM;
      end
      ARM: begin
        shreg_n   = {frame_tail(data_q, eight_q, pen_q, ohel_q), data_q[6:0], 1'b0};
        bit_cnt_n = '0;
        state_n   = SHIFT;
      end
      SHIFT: begin
        if (btu) begin
          shreg_n   = {1'b1, shreg[FRAME_BITS-1:1]};
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
    end
  end

  // Mode and divisor are latched so the frame in flight ignores later input changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      k_q     <= '0;
    end else if (accept) begin
      data_q  <= OUT_PORT;
      eight_q <= EIGHT;
      pen_q   <= PEN;
      ohel_q  <= OHEL;
      k_q     <= K;
    end
  end

  // TX is registered from next-state values so it tracks shreg[0] in SHIFT
  // on the same edge, with no combinational mux on the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q <= 1'b1;
    end else begin
      tx_q <= (state_n == SHIFT) ? shreg_n[0] : 1'b1;
    end
  end

  assign TX    = tx_q;
  assign TXRDY = (state == IDLE);

endmodule

// File: tb/tb_tx_engine.sv
// Directed bench for tx_engine: expected frame bits are queued when a byte
// is loaded and popped as the serial line is sampled.
module tb_tx_engine;

  localparam int unsigned KW = 19;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          LOAD     = 1'b0;
  logic [7:0]    OUT_PORT = '0;
  logic          EIGHT    = 1'b1;
  logic          PEN      = 1'b0;
  logic          OHEL     = 1'b0;
  logic [KW-1:0] K        = '0;
  logic          TX;
  logic          TXRDY;

  logic exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  tx_engine #(
    .KW(KW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .LOAD    (LOAD),
    .OUT_PORT(OUT_PORT),
    .EIGHT   (EIGHT),
    .PEN     (PEN),
    .OHEL    (OHEL),
    .K       (K),
    .TX      (TX),
    .TXRDY   (TXRDY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: start, 7 or 8 data bits LSB first, optional parity, stop fill to 11.
  task automatic push_frame(input logic [7:0] d, input logic eight, input logic pen,
                            input logic ohel);
    int unsigned nb;
    int unsigned pushed;
    logic        par;
    exp_q.push_back(1'b0);
    pushed = 1;
    nb     = eight ? 8 : 7;
    par    = ohel;
    for (int unsigned i = 0; i < nb; i++) begin
      exp_q.push_back(d[i]);
      par = par ^ d[i];
      pushed++;
    end
    if (pen) begin
      exp_q.push_back(par);
      pushed++;
    end
    while (pushed < 11) begin
      exp_q.push_back(1'b1);
      pushed++;
    end
  endtask

  // Called #1 after a clock edge; LOAD is high for exactly one edge.
  task automatic load_byte(input logic [7:0] d, input logic [KW-1:0] k, input logic eight,
                           input logic pen, input logic ohel);
    check("txrdy_before_load", TXRDY, 1'b1);
    OUT_PORT = d;
    K        = k;
    EIGHT    = eight;
    PEN      = pen;
    OHEL     = ohel;
    LOAD     = 1'b1;
    push_frame(d, eight, pen, ohel);
    @(posedge clk);
    #1;
    LOAD     = 1'b0;
    OUT_PORT = 8'($urandom);
    check("txrdy_after_load", TXRDY, 1'b0);
  endtask

  // Checks start latency, first and last cycle of every bit, and TXRDY timing.
  task automatic check_frame(input logic [KW-1:0] k, input int inject_bit);
    int unsigned lat;
    logic        exp_bit;
    logic        rdy_last;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (TX !== 1'b0 && lat < 50);
    check("start_latency", lat, 1);
    rdy_last = 1'b1;
    for (int i = 0; i < 11; i++) begin
      exp_bit = exp_q.pop_front();
      check($sformatf("bit%0d_first", i), TX, exp_bit);
      for (int unsigned c = 0; c < k; c++) begin
        if (i == inject_bit && c == 0) begin
          LOAD     = 1'b1;
          OUT_PORT = 8'h00;
          K        = '0;
          EIGHT    = ~EIGHT;
          PEN      = ~PEN;
          OHEL     = ~OHEL;
        end
        @(posedge clk);
        #1;
        LOAD = 1'b0;
      end
      check($sformatf("bit%0d_last", i), TX, exp_bit);
      rdy_last = TXRDY;
      @(posedge clk);
      #1;
    end
    check("txrdy_low_last_bit", rdy_last, 1'b0);
    check("txrdy_after_frame", TXRDY, 1'b1);
  endtask

  task automatic idle_check(input int unsigned n);
    logic saw_low;
    logic saw_busy;
    saw_low  = 1'b0;
    saw_busy = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (TX !== 1'b1) saw_low = 1'b1;
      if (TXRDY !== 1'b1) saw_busy = 1'b1;
    end
    check("idle_tx_high", saw_low, 1'b0);
    check("idle_txrdy_high", saw_busy, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #100;
    check("reset_tx", TX, 1'b1);
    check("reset_txrdy", TXRDY, 1'b1);

    // First LOAD lands on the first edge after reset release.
    reset = 1'b1;
    load_byte(8'h55, 19'd108, 1'b1, 1'b0, 1'b0);
    check_frame(19'd108, -1);

    idle_check(5);
    load_byte(8'hA5, 19'd4, 1'b1, 1'b1, 1'b0);
    check_frame(19'd4, -1);
    idle_check(3);
    load_byte(8'hA5, 19'd4, 1'b1, 1'b1, 1'b1);
    check_frame(19'd4, -1);

    idle_check(3);
    load_byte(8'h83, 19'd3, 1'b0, 1'b1, 1'b1);
    check_frame(19'd3, -1);

    // Mid-frame LOAD of 0x00 plus mode/divisor changes must not disturb the frame.
    idle_check(3);
    load_byte(8'h55, 19'd6, 1'b1, 1'b0, 1'b0);
    check_frame(19'd6, 4);
    idle_check(21);

    // Back-to-back: second LOAD on the cycle TXRDY rises.
    load_byte(8'h55, 19'd6, 1'b1, 1'b0, 1'b0);
    check_frame(19'd6, -1);
    load_byte(8'h0F, 19'd6, 1'b1, 1'b0, 1'b0);
    check_frame(19'd6, -1);

    idle_check(3);
    load_byte(8'hFF, 19'd0, 1'b1, 1'b0, 1'b0);
    check_frame(19'd0, -1);

    // Asynchronous reset mid-frame while TX is low.
    idle_check(2);
    load_byte(8'h00, 19'd20, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
    end
    check("midframe_tx_low", TX, 1'b0);
    #3 reset = 1'b0;
    #1;
    check("async_reset_tx", TX, 1'b1);
    check("async_reset_txrdy", TXRDY, 1'b1);
    exp_q.delete();
    #20;
    @(posedge clk);
    #1;
    reset = 1'b1;
    load_byte(8'h3C, 19'd2, 1'b1, 1'b1, 1'b0);
    check_frame(19'd2, -1);
    idle_check(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
